// File: rtl/pong_game_ctrl.sv
// Pong frame-rate controller: owns ball position/velocity, scores and serve/play/point sequencing.
// Optional RALLY_SPEEDUP_EN: each paddle return bumps the X speed by one, saturating at MAX_SPEED.
module pong_game_ctrl #(
   parameter int SCORE_W     = 4,
   parameter int WIN_SCORE   = 11,
   parameter int SERVE_DELAY = 60,
   parameter int INIT_SPEED  = 5,
   parameter int MAX_SPEED   = 12
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_tick,
   input  logic               start,
   input  logic [31:0]        dimensions,
   input  logic [31:0]        phys_pos,
   input  logic [31:0]        phys_vel,
   input  logic [1:0]         phys_score,
   output logic [31:0]        ball_pos,
   output logic [31:0]        ball_vel,
   output logic [SCORE_W-1:0] score_left,
   output logic [SCORE_W-1:0] score_right,
   output logic               game_over,
   output logic [1:0]         winner,
   output logic [2:0]         state
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SERVE = 3'd1;
   localparam logic [2:0] S_PLAY  = 3'd2;
   localparam logic [2:0] S_POINT = 3'd3;
   localparam logic [2:0] S_OVER  = 3'd4;

   localparam int                 CNT_W     = $clog2(SERVE_DELAY + 1);
   localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(SERVE_DELAY - 1);
   localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);
   localparam logic [15:0]        INIT_V    = 16'(INIT_SPEED);
   localparam logic [15:0]        INIT_N    = 16'd0 - INIT_V;
   localparam logic [31:0]        START_VEL = {INIT_V, INIT_V};

   logic [31:0]      centre;
   logic [31:0]      serve_vel;
   logic [31:0]      play_vel;
   logic             serve_dir;
   logic [CNT_W-1:0] serve_cnt;
   logic             unused_dim;

   assign centre     = {1'b0, dimensions[31:17], 1'b0, dimensions[15:1]};
   assign unused_dim = ^{dimensions[16], dimensions[0]};
   assign serve_vel  = {serve_dir ? INIT_V : INIT_N, INIT_V};
   assign game_over  = (state == S_OVER);

`ifdef RALLY_SPEEDUP_EN
   localparam logic [15:0] MAX_V = 16'(MAX_SPEED);
   logic [15:0] px_mag, nx_mag;

   // A sign flip between stored and next X velocity means a paddle return.
   always_comb begin
      px_mag   = phys_vel[31] ? (16'd0 - phys_vel[31:16]) : phys_vel[31:16];
      nx_mag   = (px_mag >= MAX_V) ? MAX_V : px_mag + 16'd1;
      play_vel = phys_vel;
      if (phys_vel[31] != ball_vel[31])
         play_vel[31:16] = phys_vel[31] ? (16'd0 - nx_mag) : nx_mag;
   end
`else
   assign play_vel = phys_vel;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         score_left  <= '0;
         score_right <= '0;
         winner      <= 2'b00;
         ball_pos    <= centre;
         ball_vel    <= START_VEL;
         serve_cnt   <= '0;
         serve_dir   <= 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state       <= S_SERVE;
                  score_left  <= '0;
                  score_right <= '0;
                  serve_cnt   <= '0;
                  ball_pos    <= centre;
                  ball_vel    <= serve_vel;
               end else if (frame_tick) begin
                  ball_pos <= centre;
               end
            end
            S_SERVE: if (frame_tick) begin
               ball_pos <= centre;
               ball_vel <= serve_vel;
               if (serve_cnt == CNT_LAST) begin
                  serve_cnt <= '0;
                  state     <= S_PLAY;
               end else begin
                  serve_cnt <= serve_cnt + CNT_W'(1);
               end
            end
            S_PLAY: if (frame_tick) begin
               if (phys_score == 2'b00) begin
                  ball_pos <= phys_pos;
                  ball_vel <= play_vel;
               end else begin
                  state    <= S_POINT;
                  ball_pos <= centre;
                  // Simultaneous flags are a void point: no score, serve side kept.
                  if (phys_score == 2'b01) begin
                     if (score_right != WIN) score_right <= score_right + SCORE_W'(1);
                     serve_dir <= 1'b1;
                  end else if (phys_score == 2'b10) begin
                     if (score_left != WIN) score_left <= score_left + SCORE_W'(1);
                     serve_dir <= 1'b0;
                  end
               end
            end
            S_POINT: if (frame_tick) begin
               if (score_left == WIN) begin
                  state  <= S_OVER;
                  winner <= 2'b01;
               end else if (score_right == WIN) begin
                  state  <= S_OVER;
                  winner <= 2'b10;
               end else begin
                  state    <= S_SERVE;
                  ball_vel <= serve_vel;
               end
            end
            S_OVER: begin
               if (start) begin
                  state       <= S_SERVE;
                  score_left  <= '0;
                  score_right <= '0;
                  winner      <= 2'b00;
                  serve_dir   <= 1'b1;
                  serve_cnt   <= '0;
                  ball_pos    <= centre;
                  ball_vel    <= START_VEL;
               end else if (frame_tick) begin
                  ball_pos <= centre;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Frame-rate game controller closing the loop around the ball physics block. It owns the architectural ball position and velocity registers and feeds them to physics. Once per frame it consumes physics' next position, velocity and score flags. It also keeps both players' scores, sequences serve, play and point phases, and declares a winner.
Packing convention (all 32-bit vectors): {X[31:16], Y[15:0]}. Dimensions are {width, height}.

Parameters:
SCORE_W, 4, width of each score counter
WIN_SCORE, 11, points needed to win; must be < 2**SCORE_W
SERVE_DELAY, 60, frame ticks ball is held at centre before release; must be >= 1
INIT_SPEED, 5, serve speed magnitude per axis (16-bit)
MAX_SPEED, 12, speed ceiling (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse, one per video frame
start  in  1  level; begins a game from IDLE or GAME_OVER
dimensions  in  32  {field width, field height}
phys_pos  in  32  next ball position from physics
phys_vel  in  32  next ball velocity from physics
phys_score  in  2  physics score flags; bit0 = ball passed left paddle, bit1 = ball passed right paddle
ball_pos  out  32  registered ball position driven to physics
ball_vel  out  32  registered ball velocity driven to physics
score_left  out  SCORE_W  left player score
score_right  out  SCORE_W  right player score
game_over  out  1  high in GAME_OVER
winner  out  2  {right, left} one-hot winner; 00 until game over
state  out  3  encoded FSM state for debug (IDLE=0, SERVE=1, PLAY=2, POINT=3, GAME_OVER=4)

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE; scores=0; winner=00; game_over=0.
  - ball_pos = centre = {{1'b0,dimensions[31:17]},{1'b0,dimensions[15:1]}}.
  - ball_vel = {+INIT_SPEED, +INIT_SPEED}.
  - serve counter=0; serve_dir=right.
  - rst overrides all other inputs in any state, mid-rally included.
- Every state change and register update happens only on a clk edge with frame_tick=1, except IDLE/GAME_OVER exits on start (no tick needed) and reset.
- IDLE:
  - ball held at centre.
  - start=1 -> SERVE; scores cleared; serve counter=0.
- SERVE:
  - ball_pos forced to centre.
  - ball_vel = {serve_dir ? +INIT_SPEED : -INIT_SPEED, +INIT_SPEED}; negation is two's complement 16-bit.
  - Each tick increments the counter. On the tick where counter == SERVE_DELAY-1 -> PLAY, counter reset to 0.
  - phys_* ignored.
- PLAY, each tick:
  - phys_score==00: ball_pos<=phys_pos, ball_vel<=phys_vel; stay in PLAY.
  - phys_score==01: score_right+1; serve_dir=right; -> POINT.
  - phys_score==10: score_left+1; serve_dir=left; -> POINT.
  - phys_score==11 (both flags, simultaneous): no score change; serve_dir unchanged; -> POINT.
  - On any point, ball_pos<=centre on the same edge.
- POINT (one tick):
  - If score_left==WIN_SCORE -> GAME_OVER, winner=01.
  - Else if score_right==WIN_SCORE -> GAME_OVER, winner=10.
  - Otherwise -> SERVE.
  - Scores never exceed WIN_SCORE; increment is suppressed if already equal.
- GAME_OVER:
  - game_over=1; ball held at centre; scores and winner frozen.
  - start=1 -> SERVE with scores=0, winner=00, serve_dir=right.
- Latency: physics outputs sampled on tick N appear on ball_pos/ball_vel after that edge, one frame of loop delay.
- dimensions may change only in IDLE. The centre is recomputed combinationally from the current dimensions each time it is loaded.

Optional Feature:
RALLY_SPEEDUP_EN:
- Defined: in PLAY with phys_score==00, if sign(phys_vel[31:16]) != sign(ball_vel[31:16]) (a paddle return), the stored X velocity magnitude is incremented by 1, saturating at MAX_SPEED, with the sign preserved. Y velocity is unaffected. Speed resets to INIT_SPEED at every SERVE.
- Undefined: phys_vel is stored verbatim; MAX_SPEED is unused.

Test Plan:
1. rst=1 with dimensions={640,480}, then release -> state=IDLE, ball_pos={320,240}, ball_vel={5,5}, scores 0, game_over=0.
2. start=1, SERVE_DELAY=60 ticks -> state=PLAY after exactly the 60th tick; ball_pos stays {320,240} through SERVE.
3. PLAY, tick with phys_pos={325,245}, phys_vel={5,5}, score 00 -> ball_pos={325,245}; a tick with score 01 -> score_right=1, ball_pos={320,240}, POINT then SERVE with ball_vel X=+5.
4. PLAY, phys_score=11 -> scores unchanged, POINT -> SERVE; ball recentred.
5. Drive 11 points with flag 10 -> winner=01, game_over=1, further flags ignored; start=1 -> scores 0, SERVE.
6. RALLY_SPEEDUP_EN: ball_vel X=+5, phys_vel X=-5 -> ball_vel X=-6; repeat to MAX_SPEED=12 -> saturates at +/-12; rst mid-PLAY -> IDLE, ball_vel {5,5}.
